// File: rtl/fir_coef_pkg.sv
// Shared types and word layout for the FIR coefficient pair loader.
// One 32-bit register word packs two 16-bit taps: [31:16] = TAP_LO, [15:0] = TAP_LO+1.
package fir_coef_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned COEF_WIDTH = 16;
    localparam int unsigned HI_LSB     = 16;
    localparam int unsigned LO_LSB     = 0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_WR_LO     = 3'd2,
        ST_WR_HI     = 3'd3,
        ST_WAIT_SYNC = 3'd4
    } state_e;

    function automatic logic [COEF_WIDTH-1:0] coef_hi(input logic [WORD_W-1:0] word);
        return word[HI_LSB +: COEF_WIDTH];
    endfunction

    function automatic logic [COEF_WIDTH-1:0] coef_lo(input logic [WORD_W-1:0] word);
        return word[LO_LSB +: COEF_WIDTH];
    endfunction

endpackage

// File: rtl/word_settle_filter.sv
// Registers the software word and reports a candidate once it has been identical
// for STABLE_CYCLES samples and differs from the currently accepted word.
module word_settle_filter
    import fir_coef_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic [WORD_W-1:0] data_in,
    input  logic [WORD_W-1:0] accepted,
    output logic              settling,
    output logic              stable_valid,
    output logic [WORD_W-1:0] stable_word
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] TARGET = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [WORD_W-1:0] in_q;
    logic [CW-1:0]     cnt;

    // stable_word doubles as the candidate; stable_valid is a one-cycle strobe that self-clears
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q         <= '0;
            cnt          <= '0;
            settling     <= 1'b0;
            stable_valid <= 1'b0;
            stable_word  <= '0;
        end else begin
            in_q <= data_in;
            if (!arm || stable_valid) begin
                cnt          <= '0;
                settling     <= 1'b0;
                stable_valid <= 1'b0;
            end else if (cnt == '0 || in_q != stable_word) begin
                if (in_q == accepted) begin
                    cnt      <= '0;
                    settling <= 1'b0;
                end else begin
                    stable_word  <= in_q;
                    cnt          <= ONE;
                    settling     <= 1'b1;
                    stable_valid <= (TARGET == ONE);
                end
            end else begin
                cnt <= cnt + ONE;
                if (cnt + ONE == TARGET) begin
                    stable_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fir_coef_pair_loader.sv
// Loads a settled coefficient pair into the shadow RAM over a ready/we handshake,
// then requests a shadow->active bank swap on the next frame sync.
module fir_coef_pair_loader
    import fir_coef_pkg::*;
#(
    parameter int unsigned TAP_LO        = 20,
    parameter int unsigned ADDR_W        = 6,
    parameter int unsigned COEF_W        = 16,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [WORD_W-1:0] user_data_in,
    input  logic              sync_in,
    input  logic              coef_ready,
    output logic              coef_we,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_swap,
    output logic              busy,
    output logic [CNT_W-1:0]  upd_count
);

    if (COEF_W != COEF_WIDTH) begin : g_bad_coef_w
        $error("fir_coef_pair_loader: COEF_W must be %0d", COEF_WIDTH);
    end
    if (TAP_LO + 1 >= (1 << ADDR_W)) begin : g_bad_tap_lo
        $error("fir_coef_pair_loader: TAP_LO+1 does not fit in ADDR_W bits");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("fir_coef_pair_loader: STABLE_CYCLES must be >= 1");
    end

    localparam logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(TAP_LO);
    localparam logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(TAP_LO + 1);

    state_e            state;
    logic [WORD_W-1:0] accepted;
    logic              filter_arm;
    logic              settling;
    logic              stable_valid;
    logic [WORD_W-1:0] stable_word;

    assign filter_arm = (state == ST_IDLE) || (state == ST_SETTLE);

    word_settle_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_settle (
        .clk         (user_clk),
        .rst         (user_rst),
        .arm         (filter_arm),
        .data_in     (user_data_in),
        .accepted    (accepted),
        .settling    (settling),
        .stable_valid(stable_valid),
        .stable_word (stable_word)
    );

    // Swap must coincide with the sync pulse itself, so it is decoded from the registered state
    assign coef_swap = (state == ST_WAIT_SYNC) && sync_in;

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state     <= ST_IDLE;
            accepted  <= '0;
            coef_we   <= 1'b0;
            coef_addr <= '0;
            coef_data <= '0;
            busy      <= 1'b0;
            upd_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_SETTLE: begin
                    if (stable_valid) begin
                        state     <= ST_WR_LO;
                        busy      <= 1'b1;
                        accepted  <= stable_word;
                        coef_we   <= 1'b1;
                        coef_addr <= ADDR_LO;
                        coef_data <= COEF_W'(coef_hi(stable_word));
                    end else if (settling) begin
                        state <= ST_SETTLE;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_WR_LO: begin
                    if (coef_ready) begin
                        state     <= ST_WR_HI;
                        coef_addr <= ADDR_HI;
                        coef_data <= COEF_W'(coef_lo(accepted));
                    end
                end
                ST_WR_HI: begin
                    if (coef_ready) begin
                        state     <= ST_WAIT_SYNC;
                        coef_we   <= 1'b0;
                        coef_addr <= '0;
                        coef_data <= '0;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (sync_in) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        upd_count <= upd_count + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    coef_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
